// File: rtl/cdc_pkg.sv
// Shared constants, types and helpers for the clk1->clk2 round-robin collector.
package cdc_pkg;

    localparam int CDC_SYNC_MIN = 3;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/cdc_en_capture.sv
// One slow-domain channel: din_en synchroniser, rising-edge detect, word holding
// register and the pending / sticky overrun flags seen by the arbiter.
module cdc_en_capture
    import cdc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int SYNC = 3
)
(
    input  logic          clk2,
    input  logic          rstn,
    input  logic [DW-1:0] i_din,
    input  logic          i_din_en,
    input  logic          i_grant,
    input  logic          i_ovf_clr,
    output logic [DW-1:0] o_hold,
    output logic          o_pend,
    output logic          o_ovf
);

    localparam int SYNC_D = (SYNC < CDC_SYNC_MIN) ? CDC_SYNC_MIN : SYNC;

    logic [SYNC_D-1:0] r_en_sync;
    logic [DW-1:0]     r_hold;
    logic              r_pend;
    logic              r_ovf;
    logic              w_pos;
    logic              w_take;

    assign w_pos = r_en_sync[SYNC_D-2] & ~r_en_sync[SYNC_D-1];
    // A new word may overwrite the holding register only when the slot is free
    // or the old word leaves through the arbiter on this very edge.
    assign w_take = w_pos & (~r_pend | i_grant);

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_en_sync <= '0;
            r_hold    <= '0;
            r_pend    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_en_sync <= {r_en_sync[SYNC_D-2:0], i_din_en};
            if (w_take)
                r_hold <= i_din;
            if (w_pos)
                r_pend <= 1'b1;
            else if (i_grant)
                r_pend <= 1'b0;
            if (w_pos && !w_take)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign o_hold = r_hold;
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/cdc_rr_collector.sv
// Collects NCH slow-domain words into one clk2 valid/ready stream tagged with the
// source channel, draining pending channels in rotating-priority order.
module cdc_rr_collector
    import cdc_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int DW   = 32,
    parameter  int SYNC = 3,
    localparam int CW   = chan_w(NCH)
)
(
    input  logic            clk2,
    input  logic            rstn,
    input  logic [NCH*DW-1:0] din,
    input  logic [NCH-1:0]  din_en,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic [CW-1:0]   m_chan,
    output logic [NCH-1:0]  ovf,
    input  logic [NCH-1:0]  ovf_clr
);

    logic [DW-1:0]  w_hold [NCH];
    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_grant;
    logic [CW-1:0]  w_gnt_idx;
    logic           w_gnt_found;
    logic           w_load;
    logic           w_fire;

    out_state_e     r_state;
    logic           r_valid;
    logic [DW-1:0]  r_data;
    logic [CW-1:0]  r_chan;
    logic [CW-1:0]  r_rr_ptr;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        cdc_en_capture #(
            .DW   (DW),
            .SYNC (SYNC)
        ) u_cap (
            .clk2      (clk2),
            .rstn      (rstn),
            .i_din     (din[c*DW +: DW]),
            .i_din_en  (din_en[c]),
            .i_grant   (w_grant[c]),
            .i_ovf_clr (ovf_clr[c]),
            .o_hold    (w_hold[c]),
            .o_pend    (w_pend[c]),
            .o_ovf     (ovf[c])
        );
        assign w_grant[c] = w_fire & (w_gnt_idx == CW'(c));
    end

    // Scan from the farthest offset down so the nearest pending channel at or
    // above rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [CW:0] w_sum;
        w_gnt_idx   = '0;
        w_gnt_found = 1'b0;
        w_sum       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (CW+1)'(i);
            if (w_sum >= (CW+1)'(NCH))
                w_sum = w_sum - (CW+1)'(NCH);
            if (w_pend[w_sum[CW-1:0]]) begin
                w_gnt_idx   = w_sum[CW-1:0];
                w_gnt_found = 1'b1;
            end
        end
    end

    assign w_load = (r_state == OUT_EMPTY) || m_ready;
    assign w_fire = w_load && w_gnt_found;

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_state  <= OUT_EMPTY;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_chan   <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_fire) begin
                r_state  <= OUT_FULL;
                r_valid  <= 1'b1;
                r_data   <= w_hold[w_gnt_idx];
                r_chan   <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + CW'(1);
            end else begin
                case (r_state)
                    OUT_FULL: begin
                        if (m_ready) begin
                            r_state <= OUT_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= OUT_EMPTY;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_chan  = r_chan;

endmodule
